seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
// - Downstream of the counter/JK stages: takes N hex nibbles (counter outputs, Q values) and drives a
//   time-multiplexed N-digit common-anode 7-segment display from one shared segment bus.
// - Latches display data into a shadow register on a load strobe so a digit never shows half-updated data.
// - Scans the digits at a divided rate with an all-off gap between digits (anti-ghosting).
// - Optionally blanks leading zeros.
// PARAMETERS
// - N_DIG     4          number of digits (2..8)
// - SCAN_DIV  50000      CLK cycles per digit slot (>= BLANK_CYC+2)
// - BLANK_CYC 8          cycles at start of each slot with all anodes off
// - LZ_BLANK  1          1 = suppress leading zeros; digit 0 is always shown
// PORTS
// - CLK       in   1        system clock, all logic on posedge
// - rst_n     in   1        asynchronous active-low reset
// - iData     in   4*N_DIG  nibble k = iData[4k+3:4k]; digit 0 is least significant
// - iLoad     in   1        1-cycle strobe: copy iData into shadow register
// - iDp       in   N_DIG    decimal point per digit, active-high; latched with iData
// - oSeg      out  7        segments {g,f,e,d,c,b,a}, active-high
// - oDp       out  1        decimal point of the active digit, active-high
// - oAn       out  N_DIG    anode enables, active-low, at most one low at any time
// - oIdx      out  3        index of the digit currently in its slot
// BEHAVIOUR
// - Reset (async, rst_n=0): shadow=0, dp shadow=0, prescaler=0, oIdx=0, oAn=all 1, oSeg=0, oDp=0.
//   Takes effect immediately and mid-slot. After release the first slot (digit 0) starts with BLANK.
// - Prescaler: counts 0..SCAN_DIV-1 and wraps. On wrap, oIdx advances: N_DIG-1 -> 0.
// - Slot FSM, per digit: BLANK (prescaler < BLANK_CYC): oAn=all 1, oSeg=0, oDp=0;
//   DRIVE (prescaler >= BLANK_CYC): oAn[oIdx]=0, others 1, oSeg=decode(shadow[oIdx]), oDp=dpsh[oIdx].
// - All outputs are registered. oIdx changes on the same edge that the prescaler wraps to 0.
// - Load: when iLoad=1 at a posedge, shadow<=iData and dpsh<=iDp on that edge. The segment register
//   follows the shadow on the next edge, so latency iLoad->oSeg is 2 cycles if the slot is in DRIVE.
//   If iLoad coincides with a slot wrap, the new slot shows the new data from its first DRIVE cycle.
//   Back-to-back loads are allowed: the last one wins. iData is ignored while iLoad=0.
// - Decode (hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
// - Leading-zero blank (LZ_BLANK=1): digit k>0 is blanked if shadow nibbles k..N_DIG-1 are all 0.
//   A blanked digit gets oSeg=0 with its anode still driven low. oDp is not blanked.
// - Width rules: prescaler width = $clog2(SCAN_DIV). oIdx is zero-extended to 3 bits.
// - Invariant (SVA-checkable): $countones(~oAn) <= 1 on every cycle.
// STRUCTURE
// - Shared package seg7_pkg: SEG_BLANK=7'h00, the 16-entry hex segment constant table,
//   and the slot state enum {BLANK, DRIVE}.
// - Sub-module hex_seg7_lut: combinational nibble -> 7-bit segment lookup using the package table.
//   Instantiated once, on the muxed shadow nibble.
// - Top module holds the prescaler, slot FSM, shadow registers, LZ mask logic and output registers.
// TESTING (bench parameters: N_DIG=4, SCAN_DIV=6, BLANK_CYC=2, LZ_BLANK=1)
// - Reset: hold rst_n=0 -> oAn=4'hF, oSeg=0, oIdx=0. Release -> 2 blank cycles, then oAn=4'hE.
// - Scan: load iData=16'h1234, free-run 24 cycles -> oIdx sequence 0,1,2,3 (6 cycles each).
//   oSeg per DRIVE phase is 66,4F,5B,06. Then oIdx wraps to 0.
// - Load timing: pulse iLoad with 16'h00A7 mid-DRIVE of digit 0 -> oSeg=07 two cycles later.
//   Digit 1 shows 77. Digits 2 and 3 show oSeg=00 (LZ) with their anodes still low.
// - All-zero: load 16'h0000 -> digit 0 shows 3F, digits 1..3 show 00. With iDp=4'b0100, oDp=1 only in digit 2's DRIVE.
// - Async reset mid-slot: assert rst_n=0 during digit 2 DRIVE -> oAn=4'hF in the same cycle,
//   with no clock edge needed. Shadow cleared: digit 0 then shows 3F after release.
// - Coincident load and wrap: iLoad=1 with 16'hFFFF on a wrap edge -> the new slot shows 71
//   on its first DRIVE cycle. One-hot anode assertion holds throughout.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry k holds the pattern for hex digit k
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        BLANK,
        DRIVE
    } slot_e;

endpackage

// File: rtl/hex_seg7_lut.sv
// Combinational hex nibble to 7-segment pattern lookup.
module hex_seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with shadow
// register, inter-digit blank gap and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIG     = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 8,
    parameter int LZ_BLANK  = 1
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic [4*N_DIG-1:0] iData,
    input  logic               iLoad,
    input  logic [N_DIG-1:0]   iDp,
    output logic [6:0]         oSeg,
    output logic               oDp,
    output logic [N_DIG-1:0]   oAn,
    output logic [2:0]         oIdx
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    logic [PW-1:0]             presc_q, presc_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      wrap;
    slot_e                     state_q, state_d;
    logic [N_DIG-1:0][3:0]     shadow_q, shadow_d;
    logic [N_DIG-1:0]          dpsh_q, dpsh_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [N_DIG-1:0]          an_q, an_d;
    logic [N_DIG-1:0]          lz;
    logic                      zero_run;
    logic [3:0]                nib;
    logic [6:0]                lut_seg;

    assign wrap    = (presc_q == PW'(SCAN_DIV - 1));
    assign presc_d = wrap ? '0 : presc_q + 1'b1;

    always_comb begin
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IW'(N_DIG - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK: if (presc_d >= PW'(BLANK_CYC)) state_d = DRIVE;
            DRIVE: if (wrap && BLANK_CYC > 0) state_d = BLANK;
        endcase
    end

    assign shadow_d = iLoad ? iData : shadow_q;
    assign dpsh_d   = iLoad ? iDp : dpsh_q;

    // Digit k>0 is suppressed when it and every higher nibble are zero
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int k = N_DIG - 1; k >= 1; k--) begin
            zero_run = zero_run & (shadow_q[k] == 4'h0);
            lz[k]    = zero_run & (LZ_BLANK != 0);
        end
    end

    // Outputs follow the committed shadow, so a load is seen one edge later
    assign nib = shadow_q[idx_d];

    hex_seg7_lut u_lut (
        .nib_i (nib),
        .seg_o (lut_seg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        if (state_d == DRIVE) begin
            an_d[idx_d] = 1'b0;
            seg_d       = lz[idx_d] ? SEG_BLANK : lut_seg;
            dp_d        = dpsh_q[idx_d];
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= '0;
            state_q  <= BLANK;
            shadow_q <= '0;
            dpsh_q   <= '0;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b0;
            an_q     <= '1;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            state_q  <= state_d;
            shadow_q <= shadow_d;
            dpsh_q   <= dpsh_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
        end
    end

    assign oSeg = seg_q;
    assign oDp  = dp_q;
    assign oAn  = an_q;
    assign oIdx = 3'(idx_q);

    a_one_anode: assert property (
        @(posedge CLK) disable iff (!rst_n) $countones(~oAn) <= 1
    );

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (N_DIG=4, SCAN_DIV=6,
// BLANK_CYC=2): vector table, corner sequences, random vs. model.
module tb_seg7_scan_driver;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [15:0] iData;
    logic        iLoad;
    logic [3:0]  iDp;
    logic [6:0]  oSeg;
    logic        oDp;
    logic [3:0]  oAn;
    logic [2:0]  oIdx;

    seg7_scan_driver #(
        .N_DIG     (4),
        .SCAN_DIV  (6),
        .BLANK_CYC (2),
        .LZ_BLANK  (1)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .iData (iData),
        .iLoad (iLoad),
        .iDp   (iDp),
        .oSeg  (oSeg),
        .oDp   (oDp),
        .oAn   (oAn),
        .oIdx  (oIdx)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] hex_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model: edges since reset release, plus shadow before/after edge
    int          m_cnt;
    logic [15:0] m_sh, m_prev;
    logic [3:0]  m_dp, m_pdp;

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_sh   = '0;
        m_prev = '0;
        m_dp   = '0;
        m_pdp  = '0;
    endtask

    task automatic check_model();
        int          p, d;
        logic [6:0]  es;
        logic [3:0]  ea;
        logic        edp;
        logic [15:0] hi;
        p   = m_cnt % 6;
        d   = (m_cnt / 6) % 4;
        es  = 7'h00;
        ea  = 4'hF;
        edp = 1'b0;
        if (rst_n && p >= 2) begin
            ea  = ~(4'b1 << d);
            hi  = m_prev >> (4 * d);
            es  = (d > 0 && hi == 0) ? 7'h00 : hex_tab[hi[3:0]];
            edp = m_pdp[d];
        end
        cmp("model_an", oAn, ea);
        cmp("model_seg", oSeg, es);
        cmp("model_dp", oDp, edp);
        cmp("model_idx", oIdx, d);
        cmp("onehot_an", ($countones(~oAn) <= 1), 1);
    endtask

    task automatic tick();
        @(posedge CLK);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_prev = m_sh;
            m_pdp  = m_dp;
            if (iLoad) begin
                m_sh = iData;
                m_dp = iDp;
            end
            m_cnt++;
        end
        #1;
        check_model();
    endtask

    task automatic run_to(int target);
        int g = 0;
        while (m_cnt < target && g < 200) begin
            tick();
            g++;
        end
        cmp("run_to_cnt", m_cnt, target);
    endtask

    typedef struct {
        logic        ld;
        logic [15:0] dat;
        logic [6:0]  seg;
        logic [3:0]  an;
        logic [2:0]  idx;
    } vec_t;

    vec_t       tbl [24];
    logic [6:0] seg_exp [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    logic [3:0] an_exp  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        for (int i = 0; i < 24; i++) begin
            int p, d;
            p = (i + 1) % 6;
            d = ((i + 1) / 6) % 4;
            tbl[i].ld  = (i == 0);
            tbl[i].dat = 16'h1234;
            tbl[i].seg = (p < 2) ? 7'h00 : seg_exp[d];
            tbl[i].an  = (p < 2) ? 4'hF : an_exp[d];
            tbl[i].idx = 3'(d);
        end

        rst_n = 1'b0;
        iLoad = 1'b0;
        iData = '0;
        iDp   = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        cmp("rst_an", oAn, 4'hF);
        cmp("rst_seg", oSeg, 7'h00);
        cmp("rst_idx", oIdx, 3'd0);
        cmp("rst_dp", oDp, 1'b0);
        rst_n = 1'b1;
        check_model();
        tick();
        cmp("post_rst_blank1", oAn, 4'hF);
        tick();
        cmp("post_rst_drive", oAn, 4'hE);
        cmp("post_rst_seg0", oSeg, 7'h3F);

        // Re-sync: restart from reset so the table starts at edge 1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 24; i++) begin
            iLoad = tbl[i].ld;
            iData = tbl[i].dat;
            tick();
            cmp("tbl_seg", oSeg, tbl[i].seg);
            cmp("tbl_an", oAn, tbl[i].an);
            cmp("tbl_idx", oIdx, tbl[i].idx);
        end
        iLoad = 1'b0;
        cmp("tbl_wrap_idx", oIdx, 3'd0);

        // Load mid-DRIVE of digit 0
        run_to(26);
        iLoad = 1'b1;
        iData = 16'h00A7;
        tick();
        iLoad = 1'b0;
        cmp("ld_lat1_seg", oSeg, 7'h66);
        tick();
        cmp("ld_lat2_seg", oSeg, 7'h07);
        run_to(32);
        cmp("ld_d1_seg", oSeg, 7'h77);
        cmp("ld_d1_an", oAn, 4'hD);
        run_to(38);
        cmp("ld_d2_lz_seg", oSeg, 7'h00);
        cmp("ld_d2_an", oAn, 4'hB);
        run_to(44);
        cmp("ld_d3_lz_seg", oSeg, 7'h00);
        cmp("ld_d3_an", oAn, 4'h7);

        // All-zero with decimal point on digit 2
        run_to(47);
        iLoad = 1'b1;
        iData = 16'h0000;
        iDp   = 4'b0100;
        tick();
        iLoad = 1'b0;
        for (int c = 49; c <= 72; c++) begin
            int p, d;
            tick();
            p = c % 6;
            d = (c / 6) % 4;
            cmp("zero_seg", oSeg,
                (p >= 2 && d == 0) ? 7'h3F : 7'h00);
            cmp("zero_dp", oDp, (p >= 2 && d == 2));
        end

        // Async reset during digit 2 DRIVE
        iLoad = 1'b1;
        iData = 16'h1234;
        iDp   = 4'b0000;
        tick();
        iLoad = 1'b0;
        run_to(87);
        cmp("pre_arst_an", oAn, 4'hB);
        #3;
        rst_n = 1'b0;
        #1;
        cmp("arst_an", oAn, 4'hF);
        cmp("arst_seg", oSeg, 7'h00);
        cmp("arst_idx", oIdx, 3'd0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        check_model();
        run_to(2);
        cmp("arst_clr_seg", oSeg, 7'h3F);
        cmp("arst_clr_an", oAn, 4'hE);

        // Load coinciding with the slot wrap into digit 1
        run_to(5);
        iLoad = 1'b1;
        iData = 16'hFFFF;
        tick();
        iLoad = 1'b0;
        cmp("wrap_idx", oIdx, 3'd1);
        cmp("wrap_blank_an", oAn, 4'hF);
        tick();
        tick();
        cmp("wrap_first_drive", oSeg, 7'h71);
        cmp("wrap_an", oAn, 4'hD);

        // Random loads, data and decimal points
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            r     = 16'($urandom);
            iLoad = ($urandom_range(3) == 0);
            iData = r >> (4 * $urandom_range(4));
            iDp   = 4'($urandom_range(15));
            tick();
        end
        iLoad = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
